// File: rtl/reg_file_fwd.sv
// Register-fetch / forward stage of the SPU pipeline.
// Holds the 128 x 128-bit architectural register file and takes writeback
// from the even and odd pipes. It reads three source operands per cycle.
// A writeback in the same cycle is bypassed straight to the read, so a value
// written at an edge is also the value captured at that edge.
// The operands are presented registered, one cycle after their addresses.
module reg_file_fwd #(
   parameter int NUM_REGS = 128,
   parameter int DATA_W   = 128,
   parameter int ADDR_W   = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              stall,
   input  logic [0:ADDR_W-1] ra_addr,
   input  logic [0:ADDR_W-1] rb_addr,
   input  logic [0:ADDR_W-1] rc_addr,
   input  logic [0:DATA_W-1] rt_wb_even,
   input  logic [0:ADDR_W-1] rt_addr_wb_even,
   input  logic              reg_write_wb_even,
   input  logic [0:DATA_W-1] rt_wb_odd,
   input  logic [0:ADDR_W-1] rt_addr_wb_odd,
   input  logic              reg_write_wb_odd,
   output logic [0:DATA_W-1] ra,
   output logic [0:DATA_W-1] rb,
   output logic [0:DATA_W-1] rc,
   output logic              out_valid
);

   logic [0:DATA_W-1] regs [NUM_REGS];

   logic [0:DATA_W-1] sel_ra_p0;
   logic [0:DATA_W-1] sel_rb_p0;
   logic [0:DATA_W-1] sel_rc_p0;

   logic [0:DATA_W-1] ra_p1;
   logic [0:DATA_W-1] rb_p1;
   logic [0:DATA_W-1] rc_p1;
   logic              vld_p1;

   // The odd pipe is the younger writer, so its value takes priority over the even pipe.
   function automatic logic [0:DATA_W-1] fwd_sel(
      input logic [0:ADDR_W-1] addr,
      input logic [0:DATA_W-1] file_val,
      input logic              we_odd,
      input logic [0:ADDR_W-1] addr_odd,
      input logic [0:DATA_W-1] data_odd,
      input logic              we_even,
      input logic [0:ADDR_W-1] addr_even,
      input logic [0:DATA_W-1] data_even
   );
      logic [0:DATA_W-1] res;
      res = file_val;
      if (we_odd && (addr_odd == addr))
         res = data_odd;
      else if (we_even && (addr_even == addr))
         res = data_even;
      return res;
   endfunction

   // Stage p0: choose each operand from the writeback bypass or the register file
   always_comb begin
      sel_ra_p0 = fwd_sel(ra_addr, regs[ra_addr],
                          reg_write_wb_odd, rt_addr_wb_odd, rt_wb_odd,
                          reg_write_wb_even, rt_addr_wb_even, rt_wb_even);
      sel_rb_p0 = fwd_sel(rb_addr, regs[rb_addr],
                          reg_write_wb_odd, rt_addr_wb_odd, rt_wb_odd,
                          reg_write_wb_even, rt_addr_wb_even, rt_wb_even);
      sel_rc_p0 = fwd_sel(rc_addr, regs[rc_addr],
                          reg_write_wb_odd, rt_addr_wb_odd, rt_wb_odd,
                          reg_write_wb_even, rt_addr_wb_even, rt_wb_even);
   end

   // Register file update: the odd write is issued last, so it wins a same-address collision
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         if (reg_write_wb_even)
            regs[rt_addr_wb_even] <= rt_wb_even;
         if (reg_write_wb_odd)
            regs[rt_addr_wb_odd] <= rt_wb_odd;
      end
   end

   // Stage p1: capture operands and valid, holding them while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         ra_p1  <= '0;
         rb_p1  <= '0;
         rc_p1  <= '0;
         vld_p1 <= 1'b0;
      end else if (!stall) begin
         ra_p1  <= sel_ra_p0;
         rb_p1  <= sel_rb_p0;
         rc_p1  <= sel_rc_p0;
         vld_p1 <= in_valid;
      end
   end

   assign ra        = ra_p1;
   assign rb        = rb_p1;
   assign rc        = rc_p1;
   assign out_valid = vld_p1;

endmodule

// File: tb/tb_reg_file_fwd.sv
// Testbench for reg_file_fwd.
// It first runs directed steps with hand-derived constants, then runs random
// traffic checked against an array model of the architectural file.
module tb_reg_file_fwd;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         stall;
   logic [0:6]   ra_addr;
   logic [0:6]   rb_addr;
   logic [0:6]   rc_addr;
   logic [0:127] rt_wb_even;
   logic [0:6]   rt_addr_wb_even;
   logic         reg_write_wb_even;
   logic [0:127] rt_wb_odd;
   logic [0:6]   rt_addr_wb_odd;
   logic         reg_write_wb_odd;
   logic [0:127] ra;
   logic [0:127] rb;
   logic [0:127] rc;
   logic         out_valid;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference state: architectural contents and the expected registered outputs
   logic [0:127] m_regs [128];
   logic [0:127] exp_ra;
   logic [0:127] exp_rb;
   logic [0:127] exp_rc;
   logic         exp_vld;

   reg_file_fwd dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .stall             (stall),
      .ra_addr           (ra_addr),
      .rb_addr           (rb_addr),
      .rc_addr           (rc_addr),
      .rt_wb_even        (rt_wb_even),
      .rt_addr_wb_even   (rt_addr_wb_even),
      .reg_write_wb_even (reg_write_wb_even),
      .rt_wb_odd         (rt_wb_odd),
      .rt_addr_wb_odd    (rt_addr_wb_odd),
      .reg_write_wb_odd  (reg_write_wb_odd),
      .ra                (ra),
      .rb                (rb),
      .rc                (rc),
      .out_valid         (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [0:127] got, input logic [0:127] exp);
      n_asserts++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance the model by one edge, then advance the DUT and sample 1 ns later.
   // A write at edge N is visible to a read at edge N. The model therefore
   // commits the writes first and reads the updated contents afterwards.
   task automatic tick();
      if (reset) begin
         foreach (m_regs[i]) m_regs[i] = '0;
         exp_ra  = '0;
         exp_rb  = '0;
         exp_rc  = '0;
         exp_vld = 1'b0;
      end else begin
         if (reg_write_wb_even) m_regs[rt_addr_wb_even] = rt_wb_even;
         if (reg_write_wb_odd)  m_regs[rt_addr_wb_odd]  = rt_wb_odd;
         if (!stall) begin
            exp_ra  = m_regs[ra_addr];
            exp_rb  = m_regs[rb_addr];
            exp_rc  = m_regs[rc_addr];
            exp_vld = in_valid;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic no_writes();
      reg_write_wb_even = 1'b0;
      reg_write_wb_odd  = 1'b0;
   endtask

   function automatic logic [0:127] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      logic [0:127] k_pat;
      k_pat = 128'h0123456789ABCDEF0123456789ABCDEF;

      reset = 1'b1; in_valid = 1'b0; stall = 1'b0;
      ra_addr = '0; rb_addr = '0; rc_addr = '0;
      rt_wb_even = '0; rt_addr_wb_even = '0; reg_write_wb_even = 1'b0;
      rt_wb_odd  = '0; rt_addr_wb_odd  = '0; reg_write_wb_odd  = 1'b0;
      foreach (m_regs[i]) m_regs[i] = 'x;
      exp_ra = 'x; exp_rb = 'x; exp_rc = 'x; exp_vld = 1'bx;

      // Reset state
      tick();
      chk("reset_ra", ra, 128'h0);
      chk("reset_vld", {127'h0, out_valid}, 128'h0);
      reset = 1'b0;

      // Fresh read after reset returns zeros
      in_valid = 1'b1; ra_addr = 7'd5; rb_addr = 7'd127; rc_addr = 7'd0;
      tick();
      chk("rd0_ra", ra, 128'h0);
      chk("rd0_rb", rb, 128'h0);
      chk("rd0_rc", rc, 128'h0);
      chk("rd0_vld", {127'h0, out_valid}, 128'h1);

      // Even write, then read on the following cycle
      rt_addr_wb_even = 7'd10; rt_wb_even = k_pat; reg_write_wb_even = 1'b1;
      tick();
      no_writes();
      ra_addr = 7'd10;
      tick();
      chk("even_wr_ra", ra, k_pat);

      // Odd write with a same-cycle bypass to rb
      rt_addr_wb_odd = 7'd20; rt_wb_odd = {8{16'hAAAA}}; reg_write_wb_odd = 1'b1;
      rb_addr = 7'd20;
      tick();
      chk("bypass_rb", rb, {8{16'hAAAA}});
      no_writes();
      tick();
      chk("reread_rb", rb, {8{16'hAAAA}});

      // Dual write to one register: the odd value is kept
      rt_addr_wb_even = 7'd7; rt_wb_even = 128'h1; reg_write_wb_even = 1'b1;
      rt_addr_wb_odd  = 7'd7; rt_wb_odd  = 128'h2; reg_write_wb_odd  = 1'b1;
      rc_addr = 7'd7;
      tick();
      chk("dual_bypass_rc", rc, 128'h2);
      no_writes();
      tick();
      chk("dual_reread_rc", rc, 128'h2);

      // Stall holds the outputs while the file is still written
      rt_addr_wb_even = 7'd12; rt_wb_even = 128'h5; reg_write_wb_even = 1'b1;
      ra_addr = 7'd12;
      tick();
      chk("pre_stall_ra", ra, 128'h5);
      no_writes();
      stall = 1'b1; in_valid = 1'b0;
      rt_addr_wb_odd = 7'd12; rt_wb_odd = 128'h9; reg_write_wb_odd = 1'b1;
      tick();
      chk("stall1_ra", ra, 128'h5);
      chk("stall1_vld", {127'h0, out_valid}, 128'h1);
      no_writes();
      tick();
      chk("stall2_ra", ra, 128'h5);
      tick();
      chk("stall3_ra", ra, 128'h5);
      stall = 1'b0;
      tick();
      chk("unstall_ra", ra, 128'h9);
      chk("unstall_vld", {127'h0, out_valid}, 128'h0);

      // Reset in mid-stream clears the file and ignores writeback in that cycle
      in_valid = 1'b1;
      rt_addr_wb_even = 7'd3; rt_wb_even = 128'hF; reg_write_wb_even = 1'b1;
      ra_addr = 7'd3;
      tick();
      chk("pre_rst_ra", ra, 128'hF);
      chk("pre_rst_vld", {127'h0, out_valid}, 128'h1);
      no_writes();
      reset = 1'b1; stall = 1'b1;
      rt_addr_wb_odd = 7'd4; rt_wb_odd = 128'hDEAD; reg_write_wb_odd = 1'b1;
      tick();
      chk("rst_ra", ra, 128'h0);
      chk("rst_vld", {127'h0, out_valid}, 128'h0);
      reset = 1'b0; stall = 1'b0;
      no_writes();
      ra_addr = 7'd3; rb_addr = 7'd4; rc_addr = 7'd3;
      tick();
      chk("post_rst_r3", ra, 128'h0);
      chk("post_rst_r4", rb, 128'h0);
      chk("post_rst_vld", {127'h0, out_valid}, 128'h1);

      // Random traffic against the model; narrow addresses to force collisions
      for (int n = 0; n < 400; n++) begin
         reset             = ($urandom_range(0, 99) < 2);
         stall             = ($urandom_range(0, 3) == 0);
         in_valid          = $urandom_range(0, 1);
         ra_addr           = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 7));
         rb_addr           = 7'($urandom_range(0, 7));
         rc_addr           = ($urandom_range(0, 3) == 0) ? ra_addr : 7'($urandom_range(0, 7));
         reg_write_wb_even = $urandom_range(0, 1);
         rt_addr_wb_even   = 7'($urandom_range(0, 7));
         rt_wb_even        = rnd128();
         reg_write_wb_odd  = $urandom_range(0, 1);
         rt_addr_wb_odd    = ($urandom_range(0, 3) == 0) ? rt_addr_wb_even : 7'($urandom_range(0, 7));
         rt_wb_odd         = rnd128();
         tick();
         chk("rand_ra", ra, exp_ra);
         chk("rand_rb", rb, exp_rb);
         chk("rand_rc", rc, exp_rc);
         chk("rand_vld", {127'h0, out_valid}, {127'h0, exp_vld});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_fwd.md
Name: reg_file_fwd

Overview:
- Register-fetch/forward (RF/FWD) stage of the SPU pipeline, sitting directly upstream of the even/odd execution units.
- Holds the 128 x 128-bit architectural register file and accepts writeback from the even and odd pipes.
- Reads three source operands per cycle with write-through bypass from the same-cycle writeback.
- Presents registered ra/rb/rc operands to the execution stage one cycle after address presentation.

Parameters:
NUM_REGS, 128, number of architectural registers
DATA_W, 128, register width in bits
ADDR_W, 7, register address width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  an instruction with valid source addresses is presented this cycle
stall  input  1  hold RF/FWD output registers
ra_addr  input  [0:6]  source register A address
rb_addr  input  [0:6]  source register B address
rc_addr  input  [0:6]  source register C address (RRR format)
rt_wb_even  input  [0:127]  even-pipe writeback value
rt_addr_wb_even  input  [0:6]  even-pipe writeback destination
reg_write_wb_even  input  1  even-pipe write enable
rt_wb_odd  input  [0:127]  odd-pipe writeback value
rt_addr_wb_odd  input  [0:6]  odd-pipe writeback destination
reg_write_wb_odd  input  1  odd-pipe write enable
ra  output  [0:127]  registered operand A to execution stage
rb  output  [0:127]  registered operand B
rc  output  [0:127]  registered operand C
out_valid  output  1  ra/rb/rc hold a valid instruction's operands

Behaviour:
- Reset (synchronous, highest priority over write and stall):
  - All NUM_REGS entries cleared to 0.
  - ra/rb/rc = 0; out_valid = 0.
  - Writeback inputs are ignored in the reset cycle.
- Write, every non-reset posedge, independent of stall and in_valid:
  - If reg_write_wb_even, regs[rt_addr_wb_even] <= rt_wb_even.
  - If reg_write_wb_odd, regs[rt_addr_wb_odd] <= rt_wb_odd.
  - Both enabled to the same address: odd value is stored; even value is discarded.
- Operand select, combinational, per source X in {a,b,c}:
  - First priority: reg_write_wb_odd and rt_addr_wb_odd == rX_addr -> rt_wb_odd.
  - Else: reg_write_wb_even and rt_addr_wb_even == rX_addr -> rt_wb_even.
  - Else: regs[rX_addr].
  - Same-cycle bypass means a register written at edge N is seen by a read captured at edge N. There is no read-before-write hazard window.
- Output capture, non-reset posedge with stall = 0:
  - ra/rb/rc <= selected operands.
  - out_valid <= in_valid.
  - Latency: address presented in cycle N produces the operand at the outputs after edge N (usable in cycle N+1).
  - Operands are captured regardless of in_valid; the consumer qualifies them with out_valid.
- stall = 1:
  - ra/rb/rc/out_valid hold their values.
  - Register file writes still occur.
  - Upstream holds the addresses stable; the first edge with stall = 0 recaptures using current file contents plus bypass.
- No hardwired-zero register: register 0 is general purpose.
- Address fields are MSB-first ([0] = MSB), matching the pipeline convention; an address is an unsigned 0..127 index.
- Simultaneous events:
  - Reset and stall: reset wins.
  - Write and read of the same address in one cycle: bypass value is used.
  - All three sources with the same address: each returns the identical value.

Test Plan:
- Reset, then in_valid=1 with ra_addr=5, rb_addr=127, rc_addr=0 -> next cycle ra=rb=rc=0, out_valid=1.
- Even write reg 10 = 128'h0123..CDEF in cycle 1; cycle 2 ra_addr=10 -> after edge 2, ra=128'h0123..CDEF.
- Same-cycle bypass: odd write reg 20 = 128'hAAAA.. while rb_addr=20 -> after that edge rb=128'hAAAA..; reading reg 20 next cycle also returns 128'hAAAA...
- Dual write to reg 7 (even=128'h1, odd=128'h2) with rc_addr=7 -> rc=128'h2 at that edge and on a later re-read.
- Stall: ra=128'h5 captured, then stall=1 for 3 cycles while reg ra_addr is rewritten to 128'h9 -> ra stays 128'h5; the first edge with stall=0 gives ra=128'h9.
- Reset mid-stream, asserted while out_valid=1 and reg 3=128'hF -> next cycle outputs 0, out_valid=0, and reading reg 3 returns 0.
